// File: rtl/imm_gen_pipe_pkg.sv
// Shared definitions for the immediate-generation pipeline stage:
// opcode constants, format codes, buffer states and XLEN legality check.
package imm_gen_pipe_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP_32  = 7'b0111011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6,
    FMT_NONE = 3'd7
  } fmt_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_t;

  function automatic bit xlen_ok(int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational RV32I/RV64I immediate decoder.
// All formats are built as 32-bit values, then sign-extended to XLEN.
module imm_decode
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int EN_CSR = 1
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_t            fmt,
  output logic            illegal
);

  localparam bit RV64 = (XLEN == 64);
  localparam bit CSR  = (EN_CSR != 0);

  logic [6:0]  op;
  logic [2:0]  f3;
  logic        is_sh;
  logic        s;
  logic [31:0] v;

  assign op    = instr[6:0];
  assign f3    = instr[14:12];
  assign is_sh = (f3 == 3'b001) || (f3 == 3'b101);
  assign s     = instr[31];

  always_comb begin
    v       = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    unique case (1'b1)
      (op == OP_LOAD),
      (op == OP_JALR): begin
        fmt = FMT_I;
        v   = {{20{s}}, instr[31:20]};
      end
      (op == OP_IMM): begin
        fmt = FMT_I;
        if (is_sh)
          v = RV64 ? {26'b0, instr[25:20]}
                   : {27'b0, instr[24:20]};
        else
          v = {{20{s}}, instr[31:20]};
      end
      (RV64 && (op == OP_IMM_32)): begin
        fmt = FMT_I;
        if (is_sh)
          v = {27'b0, instr[24:20]};
        else
          v = {{20{s}}, instr[31:20]};
      end
      (op == OP_STORE): begin
        fmt = FMT_S;
        v   = {{20{s}}, instr[31:25], instr[11:7]};
      end
      (op == OP_BRANCH): begin
        fmt = FMT_B;
        v   = {{19{s}}, s, instr[7],
               instr[30:25], instr[11:8], 1'b0};
      end
      (op == OP_LUI),
      (op == OP_AUIPC): begin
        fmt = FMT_U;
        v   = {instr[31:12], 12'b0};
      end
      (op == OP_JAL): begin
        fmt = FMT_J;
        v   = {{11{s}}, s, instr[19:12],
               instr[20], instr[30:21], 1'b0};
      end
      (op == OP_SYSTEM): begin
        if (CSR && (f3 != 3'b000)) begin
          fmt = FMT_Z;
          v   = {27'b0, instr[19:15]};
        end
      end
      (op == OP_OP),
      (RV64 && (op == OP_OP_32)): begin
        fmt = FMT_R;
      end
      (op == OP_FENCE): begin
        fmt = FMT_NONE;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  // Zero-extended fields keep bit 31 clear, so one sign extension fits all.
  assign imm = XLEN'($signed(v));

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate-generation stage: decoder in front of a 2-entry
// output/skid buffer with valid/ready handshakes on both sides.
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int EN_CSR = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [15:0]     illegal_cnt
);

  if (!xlen_ok(XLEN)) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0] d_imm;
  fmt_t            d_fmt;
  logic            d_ill;

  imm_decode #(
    .XLEN   (XLEN),
    .EN_CSR (EN_CSR)
  ) u_dec (
    .instr   (in_instr),
    .imm     (d_imm),
    .fmt     (d_fmt),
    .illegal (d_ill)
  );

  buf_state_t state_q, state_d;
  logic       acc, drn;
  logic       load_out, load_skid, promote;

  logic [XLEN-1:0] skid_imm;
  fmt_t            skid_fmt;
  logic            skid_ill;

  // Ready depends only on registered state: no out_ready->in_ready path.
  assign in_ready  = (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  assign acc       = in_valid && in_ready;
  assign drn       = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load_out  = 1'b0;
    load_skid = 1'b0;
    promote   = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          load_out = 1'b1;
          state_d  = ST_ONE;
        end
      end
      ST_ONE: begin
        if (acc && drn) begin
          load_out = 1'b1;
        end else if (acc) begin
          load_skid = 1'b1;
          state_d   = ST_TWO;
        end else if (drn) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (drn) begin
          promote = 1'b1;
          state_d = ST_ONE;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_imm     <= '0;
      out_fmt     <= FMT_NONE;
      out_illegal <= 1'b0;
    end else if (load_out) begin
      out_imm     <= d_imm;
      out_fmt     <= d_fmt;
      out_illegal <= d_ill;
    end else if (promote) begin
      out_imm     <= skid_imm;
      out_fmt     <= skid_fmt;
      out_illegal <= skid_ill;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_imm <= '0;
      skid_fmt <= FMT_NONE;
      skid_ill <= 1'b0;
    end else if (load_skid) begin
      skid_imm <= d_imm;
      skid_fmt <= d_fmt;
      skid_ill <= d_ill;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      illegal_cnt <= '0;
    else if (acc && d_ill && (illegal_cnt != 16'hFFFF))
      illegal_cnt <= illegal_cnt + 16'd1;
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances on one stimulus
// stream, scored against a queue-based reference decoder.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic out_ready;
  logic [31:0] in_instr;

  logic        ir32, ov32, ol32;
  logic [31:0] oi32;
  logic [2:0]  of32;
  logic [15:0] ic32;

  logic        ir64, ov64, ol64;
  logic [63:0] oi64;
  logic [2:0]  of64;
  logic [15:0] ic64;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .EN_CSR(1)) dut32 (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (ir32),
    .in_instr    (in_instr),
    .out_valid   (ov32),
    .out_ready   (out_ready),
    .out_imm     (oi32),
    .out_fmt     (of32),
    .out_illegal (ol32),
    .illegal_cnt (ic32)
  );

  imm_gen_pipe #(.XLEN(64), .EN_CSR(1)) dut64 (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (ir64),
    .in_instr    (in_instr),
    .out_valid   (ov64),
    .out_ready   (out_ready),
    .out_imm     (oi64),
    .out_fmt     (of64),
    .out_illegal (ol64),
    .illegal_cnt (ic64)
  );

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } item_t;

  item_t q0[$];
  item_t q1[$];
  int    cntm[2];
  bit    hold_v[2];
  item_t hold[2];
  int    checks;
  int    errors;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic item_t ref_dec(input logic [31:0] i, input int xl);
    item_t  e;
    longint x;
    logic [6:0] op;
    logic [2:0] f3;
    op = i[6:0];
    f3 = i[14:12];
    x = 0;
    e.fmt = 3'd7;
    e.ill = 1'b0;
    case (op)
      7'h03, 7'h67: begin
        e.fmt = 3'd1; x = longint'($signed(i[31:20]));
      end
      7'h13, 7'h1b: begin
        if (op == 7'h1b && xl == 32) e.ill = 1'b1;
        else begin
          e.fmt = 3'd1;
          if (f3 == 3'd1 || f3 == 3'd5)
            x = (xl == 64 && op == 7'h13) ? longint'(i[25:20])
                                          : longint'(i[24:20]);
          else
            x = longint'($signed(i[31:20]));
        end
      end
      7'h23: begin
        e.fmt = 3'd2;
        x = longint'($signed({i[31:25], i[11:7]}));
      end
      7'h63: begin
        e.fmt = 3'd3;
        x = 2 * longint'($signed({i[31], i[7], i[30:25], i[11:8]}));
      end
      7'h37, 7'h17: begin
        e.fmt = 3'd4;
        x = 4096 * longint'($signed(i[31:12]));
      end
      7'h6f: begin
        e.fmt = 3'd5;
        x = 2 * longint'($signed({i[31], i[19:12], i[20], i[30:21]}));
      end
      7'h73: begin
        if (f3 != 3'd0) begin
          e.fmt = 3'd6; x = longint'(i[19:15]);
        end
      end
      7'h33: e.fmt = 3'd0;
      7'h3b: begin
        if (xl == 64) e.fmt = 3'd0;
        else e.ill = 1'b1;
      end
      7'h0f: e.fmt = 3'd7;
      default: e.ill = 1'b1;
    endcase
    e.imm = 64'(x);
    if (xl == 32) e.imm[63:32] = 32'h0;
    return e;
  endfunction

  task automatic side(input int s, input logic ir, input logic ov,
                      input logic [63:0] oi, input logic [2:0] of,
                      input logic ol, input logic [15:0] ic);
    string p;
    item_t e;
    p = (s == 1) ? "x64" : "x32";
    if (hold_v[s]) begin
      chk({p, "_hold_imm"}, oi, hold[s].imm);
      chk({p, "_hold_fmt"}, 64'(of), 64'(hold[s].fmt));
      chk({p, "_hold_ill"}, 64'(ol), 64'(hold[s].ill));
    end
    chk({p, "_cnt"}, 64'(ic), 64'(cntm[s]));
    if (ov && out_ready) begin
      if ((s == 0 && q0.size() == 0) || (s == 1 && q1.size() == 0)) begin
        chk({p, "_unexpected_out"}, 64'(ov), 64'd0);
      end else begin
        e = (s == 1) ? q1.pop_front() : q0.pop_front();
        chk({p, "_imm"}, oi, e.imm);
        chk({p, "_fmt"}, 64'(of), 64'(e.fmt));
        chk({p, "_ill"}, 64'(ol), 64'(e.ill));
      end
    end
    hold_v[s] = ov && !out_ready;
    hold[s].imm = oi;
    hold[s].fmt = of;
    hold[s].ill = ol;
    if (in_valid && ir) begin
      e = ref_dec(in_instr, (s == 1) ? 64 : 32);
      if (s == 1) q1.push_back(e);
      else q0.push_back(e);
      if (e.ill && cntm[s] < 65535) cntm[s]++;
    end
  endtask

  // Drive at the falling edge, sample 1 ns later, then advance one cycle.
  task automatic step(input logic v, input logic [31:0] ins,
                      input logic r);
    in_valid = v;
    in_instr = ins;
    out_ready = r;
    #1;
    side(0, ir32, ov32, {32'h0, oi32}, of32, ol32, ic32);
    side(1, ir64, ov64, oi64, of64, ol64, ic64);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_model();
    q0.delete();
    q1.delete();
    for (int k = 0; k < 2; k++) begin
      cntm[k] = 0;
      hold_v[k] = 1'b0;
    end
  endtask

  task automatic dir(input string tag, input logic [31:0] ins,
                     input logic [31:0] e32, input logic [63:0] e64,
                     input logic [2:0] f);
    step(1'b1, ins, 1'b1);
    chk({tag, "_v32"}, 64'(ov32), 64'd1);
    chk({tag, "_imm32"}, {32'h0, oi32}, {32'h0, e32});
    chk({tag, "_fmt32"}, 64'(of32), 64'(f));
    chk({tag, "_imm64"}, oi64, e64);
    chk({tag, "_fmt64"}, 64'(of64), 64'(f));
    step(1'b0, 32'h0, 1'b1);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [16];
    logic [31:0] w;
    ops = '{7'h03, 7'h13, 7'h67, 7'h1b, 7'h23, 7'h63, 7'h37, 7'h17,
            7'h6f, 7'h73, 7'h33, 7'h3b, 7'h0f, 7'h7f, 7'h00, 7'h5b};
    w = $urandom;
    if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 15)];
    return w;
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_instr = 32'h0;
    out_ready = 1'b0;
    reset_model();
    repeat (2) @(negedge clk);

    chk("rst_valid", 64'(ov32), 64'd0);
    chk("rst_imm", {32'h0, oi32}, 64'd0);
    chk("rst_fmt", 64'(of32), 64'd7);
    chk("rst_ill", 64'(ol32), 64'd0);
    chk("rst_cnt", 64'(ic32), 64'd0);
    chk("rst_imm64", oi64, 64'd0);
    rst = 1'b0;
    #1;
    chk("rel_ready32", 64'(ir32), 64'd1);
    chk("rel_ready64", 64'(ir64), 64'd1);
    @(negedge clk);

    dir("addi", 32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1);
    dir("sw", 32'hFE112E23, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd2);
    dir("beq", 32'hFE000CE3, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 3'd3);
    dir("lui", 32'h800002B7, 32'h80000000, 64'hFFFFFFFF80000000, 3'd4);

    step(1'b1, 32'h00500093, 1'b0);
    step(1'b1, 32'h00A12023, 1'b0);
    chk("stall_ready", 64'(ir32), 64'd0);
    step(1'b1, 32'h0080006F, 1'b0);
    step(1'b1, 32'h0080006F, 1'b0);
    step(1'b1, 32'h0080006F, 1'b1);
    step(1'b1, 32'h0080006F, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    chk("stall_q_empty", 64'(q0.size()), 64'd0);

    for (int n = 0; n < 1500; n++)
      step($urandom_range(0, 3) != 0, rand_instr(),
           $urandom_range(0, 2) != 0);
    repeat (3) step(1'b0, 32'h0, 1'b1);
    chk("rand_q_empty", 64'(q0.size() + q1.size()), 64'd0);

    step(1'b1, 32'h0000007F, 1'b0);
    step(1'b1, 32'h0000007F, 1'b0);
    chk("two_ready", 64'(ir32), 64'd0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_valid32", 64'(ov32), 64'd0);
    chk("arst_cnt32", 64'(ic32), 64'd0);
    chk("arst_valid64", 64'(ov64), 64'd0);
    chk("arst_cnt64", 64'(ic64), 64'd0);
    reset_model();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arel_ready32", 64'(ir32), 64'd1);
    chk("arel_ready64", 64'(ir64), 64'd1);
    @(negedge clk);
    step(1'b0, 32'h0, 1'b1);
    chk("arel_valid", 64'(ov32), 64'd0);

    repeat (65537) step(1'b1, 32'h0000007F, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    chk("sat_cnt32", 64'(ic32), 64'h0000FFFF);
    chk("sat_cnt64", 64'(ic64), 64'h0000FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
